demux16_rr_sched: RTL

- Round-robin scheduler for the 1:16 demultiplexer datapath.
- Accepts one serial bit stream with a valid/ready handshake and decides which of 16 sink channels receives each beat.
- Drives the registered select code and a one-hot routed output.
- Supports per-channel enable masking, sink back-pressure and fixed-length bursts per grant.

---
 rtl/demux16_sched_pkg.sv | 15 +
 rtl/rr_pick16.sv | 31 +++
 rtl/demux16_rr_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/demux16_sched_pkg.sv
// Shared constants and types for the demux16 round-robin scheduler.
package demux16_sched_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority picker: returns the first set request strictly after ptr,
// wrapping from channel 15 back to channel 0.
module rr_pick16
  import demux16_sched_pkg::*;
(
  input  ch_vec_t          req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // Offset 16 truncates to ptr itself, so the last candidate is the pointer.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/demux16_rr_sched.sv
// Round-robin 1:16 demux scheduler with fixed-length bursts per grant.
// Optional counters xfer_cnt/revoke_cnt are built when DEMUX16_SCHED_STATS_EN is defined.
module demux16_rr_sched
  import demux16_sched_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  ch_vec_t          ch_en,
  input  ch_vec_t          ch_ready,
  output logic [SEL_W-1:0] s,
  output ch_vec_t          y,
  output ch_vec_t          y_valid,
  output logic             busy
`ifdef DEMUX16_SCHED_STATS_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [7:0]       revoke_cnt
`endif
);

  state_t           state_q;
  logic [SEL_W-1:0] s_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] beat_cnt_q;
  ch_vec_t          y_q;
  ch_vec_t          yv_q;
  logic             busy_q;

  ch_vec_t          elig;
  ch_vec_t          sel_oh;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             in_grant;
  logic             cur_en;
  logic             cur_rdy;
  logic             revoke;
  logic             accept;
  logic             last_beat;

  assign elig = ch_en & ch_ready;

  rr_pick16 u_pick (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign in_grant  = (state_q == GRANT);
  assign cur_en    = ch_en[s_q];
  assign cur_rdy   = ch_ready[s_q];
  assign sel_oh    = ch_vec_t'(1) << s_q;
  // A dropped enable outranks a valid beat in the same cycle.
  assign revoke    = in_grant && !cur_en;
  assign din_ready = in_grant && cur_en && cur_rdy;
  assign accept    = din_ready && din_valid;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      rr_ptr_q   <= SEL_W'(NUM_CH - 1);
      beat_cnt_q <= '0;
      y_q        <= '0;
      yv_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      yv_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            s_q        <= pick_idx;
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (revoke) begin
            rr_ptr_q <= s_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (accept) begin
            y_q  <= din ? sel_oh : '0;
            yv_q <= sel_oh;
            if (last_beat) begin
              rr_ptr_q   <= s_q;
              busy_q     <= 1'b0;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s       = s_q;
  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = busy_q;

`ifdef DEMUX16_SCHED_STATS_EN
  logic [31:0] xfer_cnt_q;
  logic [7:0]  revoke_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q   <= '0;
      revoke_cnt_q <= '0;
    end else begin
      if (accept) begin
        xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
      if (revoke && (revoke_cnt_q != '1)) begin
        revoke_cnt_q <= revoke_cnt_q + 8'd1;
      end
    end
  end

  assign xfer_cnt   = xfer_cnt_q;
  assign revoke_cnt = revoke_cnt_q;
`endif

endmodule
